// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO block: register word indices
// (byte offset >> 2) and the two-state bus handshake encoding.
package gpio_pkg;

  localparam logic [5:0] REG_IN         = 6'h00;
  localparam logic [5:0] REG_OUT        = 6'h01;
  localparam logic [5:0] REG_DIR        = 6'h02;
  localparam logic [5:0] REG_SET        = 6'h03;
  localparam logic [5:0] REG_CLR        = 6'h04;
  localparam logic [5:0] REG_IRQ_EN     = 6'h05;
  localparam logic [5:0] REG_IRQ_POL    = 6'h06;
  localparam logic [5:0] REG_IRQ_STATUS = 6'h07;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // Only word indices 0..7 are backed by registers; the rest answer with ERR.
  function automatic logic is_mapped(input logic [5:0] idx);
    return (idx[5:3] == 3'b000);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser with one history flop; produces single-cycle
// rise/fall pulses from consecutive synchronised samples only.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_reg [SYNC_STAGES];
  logic [WIDTH-1:0] hist_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg[0] <= '0;
    end else begin
      stage_reg[0] <= pins;
    end
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage_reg[gi] <= '0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
    end else begin
      hist_reg <= stage_reg[SYNC_STAGES-1];
    end
  end

  assign sync_val = stage_reg[SYNC_STAGES-1];
  assign rise     = sync_val & ~hist_reg;
  assign fall     = ~sync_val & hist_reg;

endmodule

// File: rtl/wb_gpio.sv
// Wishbone classic slave GPIO: per-bit direction, atomic set/clear, synchronised
// inputs, polarity-selectable edge capture and one merged level interrupt.
module wb_gpio
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             STB,
  input  logic             CYC,
  input  logic             WE,
  input  logic [31:0]      ADR,
  input  logic [31:0]      DAT_O,
  input  logic [2:0]       CTI_O,
  output logic [31:0]      DAT_I,
  output logic             ACK,
  output logic             ERR,
  output logic             RTY,
  output logic             irq,
  inout  wire  [WIDTH-1:0] gpio
);

  logic [0:0]       state_reg;
  logic [5:0]       idx_reg;
  logic             we_reg;
  logic [31:0]      wdat_reg;

  logic [WIDTH-1:0] out_reg,    out_next;
  logic [WIDTH-1:0] dir_reg,    dir_next;
  logic [WIDTH-1:0] en_reg,     en_next;
  logic [WIDTH-1:0] pol_reg,    pol_next;
  logic [WIDTH-1:0] status_reg, status_next;

  logic [WIDTH-1:0] sync_val, rise, fall, edge_hit, w1c, wdat;
  logic             resp, mapped, wr_en;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{ADR[31:8], ADR[1:0], CTI_O};

  // Address/data are captured on entry so a strobe dropped during RESP
  // still completes the access with the original request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      wdat_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (CYC && STB) begin
            state_reg <= ST_RESP;
            idx_reg   <= ADR[7:2];
            we_reg    <= WE;
            wdat_reg  <= DAT_O;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign resp   = (state_reg == ST_RESP);
  assign mapped = is_mapped(idx_reg);
  assign wr_en  = resp && we_reg && mapped;
  assign wdat   = wdat_reg[WIDTH-1:0];

  assign ACK = resp && mapped;
  assign ERR = resp && !mapped;
  assign RTY = 1'b0;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .pins     (gpio),
    .sync_val (sync_val),
    .rise     (rise),
    .fall     (fall)
  );

  assign edge_hit = (pol_reg & rise) | (~pol_reg & fall);

  always_comb begin
    out_next = out_reg;
    dir_next = dir_reg;
    en_next  = en_reg;
    pol_next = pol_reg;
    w1c      = '0;
    if (wr_en) begin
      case (idx_reg)
        REG_OUT:        out_next = wdat;
        REG_DIR:        dir_next = wdat;
        REG_SET:        out_next = out_reg | wdat;
        REG_CLR:        out_next = out_reg & ~wdat;
        REG_IRQ_EN:     en_next  = wdat;
        REG_IRQ_POL:    pol_next = wdat;
        REG_IRQ_STATUS: w1c      = wdat;
        default:        ;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the bit set.
    status_next = (status_reg & ~w1c) | edge_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg    <= '0;
      dir_reg    <= '0;
      en_reg     <= '0;
      pol_reg    <= '0;
      status_reg <= '0;
    end else begin
      out_reg    <= out_next;
      dir_reg    <= dir_next;
      en_reg     <= en_next;
      pol_reg    <= pol_next;
      status_reg <= status_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx_reg)
      REG_IN:         rdata = 32'(sync_val);
      REG_OUT:        rdata = 32'(out_reg);
      REG_DIR:        rdata = 32'(dir_reg);
      REG_IRQ_EN:     rdata = 32'(en_reg);
      REG_IRQ_POL:    rdata = 32'(pol_reg);
      REG_IRQ_STATUS: rdata = 32'(status_reg);
      default:        rdata = '0;
    endcase
  end

  assign DAT_I = resp ? rdata : 32'h0;
  assign irq   = |(status_reg & en_reg);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      assign gpio[gi] = dir_reg[gi] ? out_reg[gi] : 1'bz;
    end
  endgenerate

endmodule
